// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator: FSM states, idle row level
// and the hex key code to (row, column) map used by both emulator and scanner.
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BOUNCE_IN,
      HOLD,
      BOUNCE_OUT,
      GAP
   } state_t;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   // Returns {row_idx[1:0], col_idx[1:0]} for a hex key code.
   function automatic logic [3:0] key_map(input logic [3:0] code);
      logic [3:0] rc;
      case (code)
         4'h1: rc = {2'd0, 2'd0};
         4'h2: rc = {2'd0, 2'd1};
         4'h3: rc = {2'd0, 2'd2};
         4'hA: rc = {2'd0, 2'd3};
         4'h4: rc = {2'd1, 2'd0};
         4'h5: rc = {2'd1, 2'd1};
         4'h6: rc = {2'd1, 2'd2};
         4'hB: rc = {2'd1, 2'd3};
         4'h7: rc = {2'd2, 2'd0};
         4'h8: rc = {2'd2, 2'd1};
         4'h9: rc = {2'd2, 2'd2};
         4'hC: rc = {2'd2, 2'd3};
         4'h0: rc = {2'd3, 2'd0};
         4'hF: rc = {2'd3, 2'd1};
         4'hE: rc = {2'd3, 2'd2};
         default: rc = {2'd3, 2'd3};
      endcase
      return rc;
   endfunction

endpackage

// File: rtl/keypad_emulator_bounce_gen.sv
// Contact bounce generator: after start, emits a level beginning at init_level
// that toggles every period cycles, with done high in the last of length cycles.
module bounce_gen #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         init_level,
   input  logic [W-1:0] length,
   input  logic [W-1:0] period,
   output logic         level,
   output logic         done
);

   logic         active;
   logic [W-1:0] cnt;
   logic [W-1:0] per_cnt;

   assign done = active & (cnt == length - W'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         active  <= 1'b0;
         cnt     <= '0;
         per_cnt <= '0;
         level   <= 1'b0;
      end else if (start) begin
         active  <= 1'b1;
         cnt     <= '0;
         per_cnt <= '0;
         level   <= init_level;
      end else if (active) begin
         if (done) begin
            active <= 1'b0;
         end
         cnt <= cnt + W'(1);
         if (per_cnt == period - W'(1)) begin
            per_cnt <= '0;
            level   <= ~level;
         end else begin
            per_cnt <= per_cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: behaves as a physical 4x4 matrix keypad towards a scanner,
// pressing one commanded key with optional bounce, holding it, then releasing.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_CYCLES   = 200000,
   parameter int MIN_SCANS     = 4,
   parameter int BOUNCE_CYCLES = 64,
   parameter int BOUNCE_PERIOD = 8,
   parameter int GAP_CYCLES    = 100000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ready,
   input  logic [3:0] col,
   output logic [3:0] row,
   output logic       busy,
   output logic       contact
);

   localparam int MAX_AB  = (HOLD_CYCLES > MIN_SCANS) ? HOLD_CYCLES : MIN_SCANS;
   localparam int MAX_CD  = (BOUNCE_CYCLES > BOUNCE_PERIOD) ? BOUNCE_CYCLES : BOUNCE_PERIOD;
   localparam int MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int MAXP    = (MAX_ABC > GAP_CYCLES) ? MAX_ABC : GAP_CYCLES;
   localparam int CW      = $clog2(MAXP + 1);
   localparam bit HAS_BOUNCE = (BOUNCE_CYCLES != 0);

   state_t        state;
   logic [1:0]    row_idx;
   logic [1:0]    col_idx;
   logic [3:0]    col_q;
   logic [CW-1:0] hold_cnt;
   logic [CW-1:0] scan_cnt;
   logic [CW-1:0] gap_cnt;
   logic [3:0]    new_map;
   logic [1:0]    cur_col;
   logic          accept;
   logic          scan_edge;
   logic          hold_done;
   logic          bounce_start;
   logic          bounce_level;
   logic          bounce_done;

   assign new_map   = key_map(key_code);
   assign accept    = key_valid & key_ready;
   // With no bounce, HOLD starts on the accept edge before the column is latched.
   assign cur_col   = (state == IDLE) ? new_map[1:0] : col_idx;
   assign scan_edge = col_q[cur_col] & ~col[cur_col];
   assign hold_done = (hold_cnt >= CW'(HOLD_CYCLES)) && (scan_cnt >= CW'(MIN_SCANS));
   assign bounce_start = HAS_BOUNCE &&
                         (((state == IDLE) && accept) || ((state == HOLD) && hold_done));

   bounce_gen #(
      .W(CW)
   ) u_bounce (
      .clk       (clk),
      .reset     (reset),
      .start     (bounce_start),
      .init_level(state == IDLE),
      .length    (CW'(BOUNCE_CYCLES)),
      .period    (CW'(BOUNCE_PERIOD)),
      .level     (bounce_level),
      .done      (bounce_done)
   );

   assign contact = (state == HOLD) |
                    (((state == BOUNCE_IN) | (state == BOUNCE_OUT)) & bounce_level);

   always_comb begin
      row = ROW_IDLE;
      if (contact && !col[col_idx]) begin
         row[row_idx] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         key_ready <= 1'b1;
         busy      <= 1'b0;
         row_idx   <= '0;
         col_idx   <= '0;
         col_q     <= ROW_IDLE;
         hold_cnt  <= '0;
         scan_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         col_q <= col;
         case (state)
            IDLE: begin
               if (accept) begin
                  row_idx   <= new_map[3:2];
                  col_idx   <= new_map[1:0];
                  key_ready <= 1'b0;
                  busy      <= 1'b1;
                  hold_cnt  <= '0;
                  gap_cnt   <= '0;
                  if (HAS_BOUNCE) begin
                     state    <= BOUNCE_IN;
                     scan_cnt <= '0;
                  end else begin
                     state    <= HOLD;
                     scan_cnt <= CW'(scan_edge);
                  end
               end
            end
            BOUNCE_IN: begin
               if (bounce_done) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                  scan_cnt <= CW'(scan_edge);
                  gap_cnt  <= '0;
               end
            end
            HOLD: begin
               if (hold_done) begin
                  state    <= HAS_BOUNCE ? BOUNCE_OUT : GAP;
                  hold_cnt <= '0;
                  scan_cnt <= '0;
                  gap_cnt  <= '0;
               end else begin
                  if (hold_cnt < CW'(HOLD_CYCLES)) begin
                     hold_cnt <= hold_cnt + CW'(1);
                  end
                  if (scan_edge && (scan_cnt < CW'(MIN_SCANS))) begin
                     scan_cnt <= scan_cnt + CW'(1);
                  end
               end
            end
            BOUNCE_OUT: begin
               if (bounce_done) begin
                  state   <= GAP;
                  gap_cnt <= '0;
               end
            end
            GAP: begin
               if (int'(gap_cnt) + 1 >= GAP_CYCLES) begin
                  state     <= IDLE;
                  key_ready <= 1'b1;
                  busy      <= 1'b0;
                  gap_cnt   <= '0;
               end else begin
                  gap_cnt <= gap_cnt + CW'(1);
               end
            end
            default: begin
               state     <= IDLE;
               key_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one bouncing instance and one with
// bounce disabled, both with short hold/gap timing so full presses fit.
module tb_keypad_emulator;

   logic       clk;
   logic       reset;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [3:0] col;
   logic [3:0] row;
   logic       busy;
   logic       contact;

   logic       key_valid_nb;
   logic [3:0] key_code_nb;
   logic       key_ready_nb;
   logic [3:0] col_nb;
   logic [3:0] row_nb;
   logic       busy_nb;
   logic       contact_nb;

   int checks = 0;
   int errors = 0;

   keypad_emulator #(
      .HOLD_CYCLES(20), .MIN_SCANS(2), .BOUNCE_CYCLES(8), .BOUNCE_PERIOD(2), .GAP_CYCLES(10)
   ) dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .key_ready(key_ready), .col(col), .row(row), .busy(busy), .contact(contact)
   );

   keypad_emulator #(
      .HOLD_CYCLES(20), .MIN_SCANS(2), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(2), .GAP_CYCLES(10)
   ) dut_nb (
      .clk(clk), .reset(reset), .key_valid(key_valid_nb), .key_code(key_code_nb),
      .key_ready(key_ready_nb), .col(col_nb), .row(row_nb), .busy(busy_nb),
      .contact(contact_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Column drive with exactly one bit low, rotating 0..3.
   function automatic logic [3:0] rot(input int i);
      logic [3:0] v;
      v = 4'b1111;
      v[i % 4] = 1'b0;
      return v;
   endfunction

   function automatic logic [3:0] exp_row(input logic c, input logic [3:0] colv,
                                          input int r, input int ci);
      logic [3:0] v;
      v = 4'b1111;
      if (c && !colv[ci]) v[r] = 1'b0;
      return v;
   endfunction

   task automatic send(input logic [3:0] code);
      key_valid = 1'b1;
      key_code  = code;
      cycle();
      key_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      col = 4'b0000;
      col_nb = 4'b0000;
      key_valid = 1'b0;
      key_code = 4'h0;
      key_valid_nb = 1'b0;
      key_code_nb = 4'h0;
      cycle();
      cycle();
      checks++; if (row !== 4'b1111) begin errors++; $display("[TB] FAIL reset_row got %b want 1111", row); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", key_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (contact !== 1'b0) begin errors++; $display("[TB] FAIL reset_contact got %b want 0", contact); end
      checks++; if (row_nb !== 4'b1111) begin errors++; $display("[TB] FAIL reset_row_nb got %b want 1111", row_nb); end
      reset = 1'b0;
      col = 4'b1111;
      col_nb = 4'b1111;
      cycle();
   endtask

   // Key 5 at (1,1): bounce t=0..7, HOLD t=8..37 (col[1] edges at t=20,36),
   // bounce out t=38..45, gap t=46..55, ready again at t=56.
   task automatic test_press_scan();
      logic ec, prev;
      int toggles, run, max_run;
      col = 4'b1111;
      send(4'h5);
      prev = 1'b0;
      toggles = 0;
      run = 0;
      max_run = 0;
      for (int t = 0; t < 58; t++) begin
         col = rot(t / 4);
         #1;
         if (t < 8) ec = ((t / 2) % 2) == 0;
         else if (t < 38) ec = 1'b1;
         else if (t < 46) ec = (((t - 38) / 2) % 2) == 1;
         else ec = 1'b0;
         checks++; if (contact !== ec) begin errors++; $display("[TB] FAIL press5_contact t=%0d got %b want %b", t, contact, ec); end
         checks++; if (row !== exp_row(ec, col, 1, 1)) begin errors++; $display("[TB] FAIL press5_row t=%0d got %b want %b", t, row, exp_row(ec, col, 1, 1)); end
         checks++; if (key_ready !== (t >= 56)) begin errors++; $display("[TB] FAIL press5_ready t=%0d got %b want %b", t, key_ready, t >= 56); end
         checks++; if (busy !== (t < 56)) begin errors++; $display("[TB] FAIL press5_busy t=%0d got %b want %b", t, busy, t < 56); end
         if (t < 8 && contact !== prev) toggles++;
         prev = contact;
         if (contact === 1'b1) run++; else run = 0;
         if (run > max_run) max_run = run;
         cycle();
      end
      checks++; if (toggles != 4) begin errors++; $display("[TB] FAIL press5_bounce_toggles got %0d want 4", toggles); end
      checks++; if (max_run < 20) begin errors++; $display("[TB] FAIL press5_steady_run got %0d want >=20", max_run); end
   endtask

   // Key D at (3,3) with no scanning: must stay in HOLD. A command for key 1
   // during HOLD and during GAP is ignored. Scanning then releases after
   // col[3] edges at s=12 and s=28: bounce out s=30..37, gap s=38..47.
   task automatic test_hold_busy_ignore();
      logic ec;
      col = 4'b1111;
      send(4'hD);
      for (int t = 0; t < 108; t++) begin
         col = 4'b1111;
         key_valid = (t == 50);
         key_code  = 4'h1;
         #1;
         if (t >= 8) begin
            checks++; if (contact !== 1'b1) begin errors++; $display("[TB] FAIL noscan_contact t=%0d got %b want 1", t, contact); end
            checks++; if (row !== 4'b1111) begin errors++; $display("[TB] FAIL noscan_row t=%0d got %b want 1111", t, row); end
            checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL noscan_busy t=%0d got %b want 1", t, busy); end
            checks++; if (key_ready !== 1'b0) begin errors++; $display("[TB] FAIL noscan_ready t=%0d got %b want 0", t, key_ready); end
         end
         cycle();
      end
      key_valid = 1'b0;
      for (int s = 0; s < 80; s++) begin
         col = rot(s / 4);
         key_valid = (s == 40);
         #1;
         if (s < 30) ec = 1'b1;
         else if (s < 38) ec = (((s - 30) / 2) % 2) == 1;
         else ec = 1'b0;
         checks++; if (contact !== ec) begin errors++; $display("[TB] FAIL scanD_contact s=%0d got %b want %b", s, contact, ec); end
         checks++; if (row !== exp_row(ec, col, 3, 3)) begin errors++; $display("[TB] FAIL scanD_row s=%0d got %b want %b", s, row, exp_row(ec, col, 3, 3)); end
         checks++; if (busy !== (s < 48)) begin errors++; $display("[TB] FAIL scanD_busy s=%0d got %b want %b", s, busy, s < 48); end
         checks++; if (key_ready !== (s >= 48)) begin errors++; $display("[TB] FAIL scanD_ready s=%0d got %b want %b", s, key_ready, s >= 48); end
         cycle();
      end
      key_valid = 1'b0;
   endtask

   task automatic test_reset_mid_hold();
      col = 4'b1111;
      send(4'hA);
      for (int t = 0; t < 11; t++) cycle();
      col = 4'b0111;
      #1;
      checks++; if (contact !== 1'b1) begin errors++; $display("[TB] FAIL holdA_contact got %b want 1", contact); end
      checks++; if (row !== 4'b1110) begin errors++; $display("[TB] FAIL holdA_row got %b want 1110", row); end
      reset = 1'b1;
      cycle();
      checks++; if (contact !== 1'b0) begin errors++; $display("[TB] FAIL midreset_contact got %b want 0", contact); end
      checks++; if (row !== 4'b1111) begin errors++; $display("[TB] FAIL midreset_row got %b want 1111", row); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready got %b want 1", key_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
      reset = 1'b0;
      cycle();
      cycle();
      checks++; if (busy !== 1'b0 || contact !== 1'b0) begin errors++; $display("[TB] FAIL midreset_discard got busy=%b contact=%b want 0 0", busy, contact); end
      col = 4'b1111;
   endtask

   // Key 0 at (3,0) with no bounce: HOLD t=0..20 (col[0] edges t=0,16),
   // gap t=21..30, ready at t=31.
   task automatic test_no_bounce();
      logic ec, prev;
      int rises, falls;
      col_nb = 4'b1111;
      key_valid_nb = 1'b1;
      key_code_nb = 4'h0;
      cycle();
      key_valid_nb = 1'b0;
      prev = 1'b0;
      rises = 0;
      falls = 0;
      for (int t = 0; t < 41; t++) begin
         col_nb = rot(t / 4);
         #1;
         ec = (t <= 20);
         checks++; if (contact_nb !== ec) begin errors++; $display("[TB] FAIL nobounce_contact t=%0d got %b want %b", t, contact_nb, ec); end
         checks++; if (row_nb !== exp_row(ec, col_nb, 3, 0)) begin errors++; $display("[TB] FAIL nobounce_row t=%0d got %b want %b", t, row_nb, exp_row(ec, col_nb, 3, 0)); end
         checks++; if (key_ready_nb !== (t >= 31)) begin errors++; $display("[TB] FAIL nobounce_ready t=%0d got %b want %b", t, key_ready_nb, t >= 31); end
         if (contact_nb === 1'b1 && prev === 1'b0) rises++;
         if (contact_nb === 1'b0 && prev === 1'b1) falls++;
         prev = contact_nb;
         cycle();
      end
      checks++; if (rises != 1 || falls != 1) begin errors++; $display("[TB] FAIL nobounce_edges got rises=%0d falls=%0d want 1 1", rises, falls); end
   endtask

   initial begin
      test_reset();
      test_press_scan();
      test_hold_busy_ignore();
      test_reset_mid_hold();
      test_no_bounce();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
